// File: rtl/posit_field_extract.sv
// Posit field extraction: splits a pre-decoded posit into sign, regime k, exponent and mantissa.
// Optional POSIT_EXTRACT_SPECIAL_EN adds out_zero/out_nar flags for the all-zero remainder patterns.
module posit_field_extract #(
   parameter int N  = 8,
   parameter int ES = 3,
   parameter int RS = $clog2(N)
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic                 in_sign,
   input  logic [N-2:0]         in_remain,
   input  logic [RS:0]          in_endpos,
   input  logic                 in_rc,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic                 out_sign,
   output logic signed [RS:0]   out_k,
   output logic [ES-1:0]        out_exp,
   output logic [N-ES-3:0]      out_mant
`ifdef POSIT_EXTRACT_SPECIAL_EN
   ,
   output logic                 out_zero,
   output logic                 out_nar
`endif
);

   localparam int KW = RS + 1;
   localparam int MW = N - ES - 2;
   localparam int FW = N - ES - 3;
   localparam int AW = N - 3;

   function automatic logic [KW-1:0] run_length(input logic [N-2:0] rem,
                                                input logic [KW-1:0] endpos,
                                                input logic          rc);
      if (endpos == KW'(N-2) && rem[0] == rc)
         return KW'(N-1);
      return endpos;
   endfunction

   function automatic logic signed [KW-1:0] regime_k(input logic [KW-1:0] m,
                                                     input logic          rc);
      return rc ? $signed(m - KW'(1)) : $signed(KW'(0) - m);
   endfunction

   // At most N-1 bits can be consumed: a saturated run has no terminating bit.
   function automatic logic [N-2:0] align_remainder(input logic [N-2:0]  rem,
                                                    input logic [KW-1:0] m);
      logic [KW-1:0] shamt;
      shamt = (m >= KW'(N-1)) ? KW'(N-1) : m + KW'(1);
      return rem << shamt;
   endfunction

   logic                 vld_p1, vld_p2;
   logic                 adv_p1, adv_p2;
   logic                 sign_p1, sign_p2;
   logic signed [KW-1:0] k_p1, k_p2;
   logic [AW-1:0]        rem_p1;
   logic [ES-1:0]        exp_p2;
   logic [MW-1:0]        mant_p2;

   logic [KW-1:0]        m_c;
   logic signed [KW-1:0] k_c;
   logic [N-2:0]         aligned_c;
   logic [ES-1:0]        exp_c;
   logic [MW-1:0]        mant_c;
   logic [1:0]           unused_aligned;

   assign adv_p2   = !vld_p2 || out_ready;
   assign adv_p1   = !vld_p1 || adv_p2;
   assign in_ready = adv_p1;

   // The two lowest aligned bits are always shifted-in zeros.
   assign unused_aligned = aligned_c[1:0];

`ifdef POSIT_EXTRACT_SPECIAL_EN
   logic zero_c, nar_c, special_c;
   logic zero_p1, nar_p1, zero_p2, nar_p2;

   assign special_c = (in_remain == '0);
   assign zero_c    = special_c && !in_sign;
   assign nar_c     = special_c && in_sign;

   always_comb begin
      m_c       = run_length(in_remain, in_endpos, in_rc);
      k_c       = regime_k(m_c, in_rc);
      aligned_c = align_remainder(in_remain, m_c);
      if (special_c) begin
         k_c       = '0;
         aligned_c = '0;
      end
   end
`else
   always_comb begin
      m_c       = run_length(in_remain, in_endpos, in_rc);
      k_c       = regime_k(m_c, in_rc);
      aligned_c = align_remainder(in_remain, m_c);
   end
`endif

   // ---- stage 1: sign, k, aligned remainder ----
   always_ff @(posedge clk) begin
      if (rst)
         vld_p1 <= 1'b0;
      else if (adv_p1)
         vld_p1 <= in_valid;
   end

   always_ff @(posedge clk) begin
      if (adv_p1 && in_valid) begin
         sign_p1 <= in_sign;
         k_p1    <= k_c;
         rem_p1  <= aligned_c[N-2:2];
`ifdef POSIT_EXTRACT_SPECIAL_EN
         zero_p1 <= zero_c;
         nar_p1  <= nar_c;
`endif
      end
   end

   always_comb begin
      exp_c  = rem_p1[AW-1 -: ES];
      mant_c = {1'b1, rem_p1[AW-1-ES -: FW]};
`ifdef POSIT_EXTRACT_SPECIAL_EN
      if (zero_p1 || nar_p1)
         mant_c = '0;
`endif
   end

   // ---- stage 2: split exponent / mantissa ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2  <= 1'b0;
         sign_p2 <= 1'b0;
         k_p2    <= '0;
         exp_p2  <= '0;
         mant_p2 <= '0;
`ifdef POSIT_EXTRACT_SPECIAL_EN
         zero_p2 <= 1'b0;
         nar_p2  <= 1'b0;
`endif
      end else if (adv_p2) begin
         vld_p2 <= vld_p1;
         if (vld_p1) begin
            sign_p2 <= sign_p1;
            k_p2    <= k_p1;
            exp_p2  <= exp_c;
            mant_p2 <= mant_c;
`ifdef POSIT_EXTRACT_SPECIAL_EN
            zero_p2 <= zero_p1;
            nar_p2  <= nar_p1;
`endif
         end
      end
   end

   assign out_valid = vld_p2;
   assign out_sign  = sign_p2;
   assign out_k     = k_p2;
   assign out_exp   = exp_p2;
   assign out_mant  = mant_p2;
`ifdef POSIT_EXTRACT_SPECIAL_EN
   assign out_zero  = zero_p2;
   assign out_nar   = nar_p2;
`endif

endmodule

// File: tb/tb_posit_field_extract.sv
// Directed + random bench for posit_field_extract (N=8, ES=3) with an expected-result queue.
module tb_posit_field_extract;

   localparam int N  = 8;
   localparam int ES = 3;
   localparam int RS = 3;

   typedef struct packed {
      logic          sign;
      logic [RS:0]   k;
      logic [ES-1:0] e;
      logic [N-ES-3:0] m;
      logic          z;
      logic          n;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic            in_sign = 1'b0;
   logic [N-2:0]    in_remain = '0;
   logic [RS:0]     in_endpos = 4'd1;
   logic            in_rc = 1'b0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic            out_sign;
   logic [RS:0]     out_k;
   logic [ES-1:0]   out_exp;
   logic [N-ES-3:0] out_mant;
`ifdef POSIT_EXTRACT_SPECIAL_EN
   logic            out_zero;
   logic            out_nar;
`endif

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   exp_t sb[$];
   bit   held = 0;
   logic [10:0] held_fields;

   posit_field_extract #(.N(N), .ES(ES), .RS(RS)) dut (
      .clk(clk), .rst(rst),
      .in_valid(in_valid), .in_ready(in_ready),
      .in_sign(in_sign), .in_remain(in_remain), .in_endpos(in_endpos), .in_rc(in_rc),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_sign(out_sign), .out_k(out_k), .out_exp(out_exp), .out_mant(out_mant)
`ifdef POSIT_EXTRACT_SPECIAL_EN
      , .out_zero(out_zero), .out_nar(out_nar)
`endif
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic int run_of(input logic [N-2:0] rem);
      int r = 0;
      for (int i = N-2; i >= 0; i--) begin
         if (rem[i] !== rem[N-2]) break;
         r++;
      end
      return r;
   endfunction

   function automatic exp_t model(input logic s, input logic [N-2:0] rem);
      exp_t e;
      int   m, used, p;
      m      = run_of(rem);
      e.sign = s;
      e.k    = rem[N-2] ? (RS+1)'(m-1) : (RS+1)'(-m);
      used   = (m+1 < N-1) ? m+1 : N-1;
      p      = N-2-used;
      for (int j = 0; j < ES; j++)
         e.e[ES-1-j] = (p-j >= 0) ? rem[p-j] : 1'b0;
      e.m[N-ES-3] = 1'b1;
      for (int j = 0; j < N-ES-3; j++)
         e.m[N-ES-4-j] = (p-ES-j >= 0) ? rem[p-ES-j] : 1'b0;
      e.z = 1'b0;
      e.n = 1'b0;
`ifdef POSIT_EXTRACT_SPECIAL_EN
      if (rem == '0) begin
         e.k = '0; e.e = '0; e.m = '0;
         e.z = !s; e.n = s;
      end
`endif
      return e;
   endfunction

   // Presents one operand, waits (bounded) for acceptance and queues its expectation.
   task automatic drive(input logic s, input logic [N-2:0] rem, input exp_t e);
      int  r;
      bit  ok;
      r = run_of(rem);
      in_sign   = s;
      in_remain = rem;
      in_rc     = rem[N-2];
      in_endpos = (RS+1)'((r < N-2) ? r : N-2);
      in_valid  = 1'b1;
      ok = 0;
      for (int i = 0; i < 50 && !ok; i++) begin
         @(negedge clk);
         ok = in_ready;
         @(posedge clk);
         #1;
      end
      if (ok) sb.push_back(e);
      checks++;
      assert (ok) else begin
         errors++;
         $error("FAIL accept_timeout: observed in_ready=0 expected 1");
      end
   endtask

   task automatic send(input logic s, input logic [N-2:0] rem);
      drive(s, rem, model(s, rem));
   endtask

   task automatic idle();
      in_valid  = 1'b0;
      in_sign   = 1'($urandom);
      in_remain = (N-1)'($urandom);
      in_endpos = (RS+1)'($urandom);
      in_rc     = 1'($urandom);
   endtask

   // Scoreboard side: compares each consumed result and checks stalled outputs stay put.
   always @(negedge clk) begin
      if (rst) begin
         held = 0;
      end else begin
         if (held) begin
            check("hold_valid", {31'd0, out_valid}, 32'd1);
            check("hold_fields", {21'd0, out_sign, out_k, out_exp, out_mant}, {21'd0, held_fields});
         end
         if (out_valid && out_ready) begin
            held = 0;
            checks++;
            assert (sb.size() != 0) else begin
               errors++;
               $error("FAIL unexpected_result: observed k=%0h expected no output", out_k);
            end
            if (sb.size() != 0) begin
               exp_t e;
               e = sb.pop_front();
               check("sign", {31'd0, out_sign}, {31'd0, e.sign});
               check("k", {28'd0, out_k}, {28'd0, e.k});
               check("exp", {29'd0, out_exp}, {29'd0, e.e});
               check("mant", {29'd0, out_mant}, {29'd0, e.m});
`ifdef POSIT_EXTRACT_SPECIAL_EN
               check("zero", {31'd0, out_zero}, {31'd0, e.z});
               check("nar", {31'd0, out_nar}, {31'd0, e.n});
`endif
            end
         end else if (out_valid) begin
            held = 1;
            held_fields = {out_sign, out_k, out_exp, out_mant};
         end else begin
            held = 0;
         end
      end
   end

   initial begin
      exp_t lit;
      int   c0;
      bit   done;

      // Reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check("rst_out_sign", {31'd0, out_sign}, 32'd0);
      check("rst_out_k", {28'd0, out_k}, 32'd0);
      check("rst_out_exp", {29'd0, out_exp}, 32'd0);
      check("rst_out_mant", {29'd0, out_mant}, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      check("ready_after_rst", {31'd0, in_ready}, 32'd1);

      // Reference vectors with literal expectations
      lit = '{sign: 1'b0, k: 4'b0000, e: 3'b110, m: 3'b110, z: 1'b0, n: 1'b0};
      drive(1'b0, 7'b1011010, lit);
      idle();
      c0 = cyc;
      lit = '{sign: 1'b1, k: 4'b1101, e: 3'b101, m: 3'b100, z: 1'b0, n: 1'b0};
      drive(1'b1, 7'b0001101, lit);
      idle();
      @(negedge clk);
      @(negedge clk);
      check("latency", {31'd0, out_valid}, 32'd1);
      check("latency_k", {28'd0, out_k}, {28'd0, 4'b1101});
      @(posedge clk);
      #1;
      lit = '{sign: 1'b0, k: 4'b0110, e: 3'b000, m: 3'b100, z: 1'b0, n: 1'b0};
      drive(1'b0, 7'b1111111, lit);
      idle();

      // All-zero remainder, both signs
`ifdef POSIT_EXTRACT_SPECIAL_EN
      lit = '{sign: 1'b1, k: 4'b0000, e: 3'b000, m: 3'b000, z: 1'b0, n: 1'b1};
      drive(1'b1, 7'b0000000, lit);
      lit = '{sign: 1'b0, k: 4'b0000, e: 3'b000, m: 3'b000, z: 1'b1, n: 1'b0};
      drive(1'b0, 7'b0000000, lit);
`else
      lit = '{sign: 1'b1, k: 4'b1001, e: 3'b000, m: 3'b100, z: 1'b0, n: 1'b0};
      drive(1'b1, 7'b0000000, lit);
      lit = '{sign: 1'b0, k: 4'b1001, e: 3'b000, m: 3'b100, z: 1'b0, n: 1'b0};
      drive(1'b0, 7'b0000000, lit);
`endif
      send(1'b0, 7'b1111110);
      send(1'b0, 7'b0000001);
      idle();

      // Throughput: four operands in four cycles with the consumer always ready
      repeat (4) @(posedge clk);
      #1;
      c0 = cyc;
      send(1'b0, 7'b1100101);
      send(1'b1, 7'b0110011);
      send(1'b0, 7'b1010101);
      send(1'b1, 7'b0011110);
      check("throughput_cycles", cyc - c0, 32'd4);
      idle();

      // Back-pressure: consumer stalls three cycles during a burst
      repeat (4) @(posedge clk);
      #1;
      out_ready = 1'b0;
      fork
         begin
            send(1'b0, 7'b1110001);
            send(1'b1, 7'b0100110);
            send(1'b0, 7'b1001011);
            send(1'b0, 7'b0011011);
            idle();
         end
         begin
            repeat (3) @(posedge clk);
            #1;
            check("stall_in_ready", {31'd0, in_ready}, 32'd0);
            out_ready = 1'b1;
         end
      join

      // Random operands under random back-pressure
      done = 0;
      fork
         begin
            for (int i = 0; i < 24; i++) begin
               logic [N-2:0] r;
               r = (N-1)'($urandom);
               send(1'($urandom), r);
               if ($urandom_range(0, 3) == 0) begin
                  idle();
                  @(posedge clk);
                  #1;
               end
            end
            idle();
            done = 1;
         end
         begin
            while (!done) begin
               @(posedge clk);
               #1;
               out_ready = 1'($urandom);
            end
            out_ready = 1'b1;
         end
      join
      for (int i = 0; i < 200 && sb.size() != 0; i++) @(posedge clk);
      #1;
      check("drain_before_reset", sb.size(), 32'd0);

      // Reset with two operands in flight
      out_ready = 1'b0;
      send(1'b0, 7'b1011010);
      send(1'b1, 7'b0001101);
      idle();
      rst = 1'b1;
      sb.delete();
      @(posedge clk);
      #1;
      check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
      check("midrst_out_k", {28'd0, out_k}, 32'd0);
      rst = 1'b0;
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
      check("midrst_no_stale", {31'd0, out_valid}, 32'd0);
      repeat (5) @(posedge clk);
      #1;
      send(1'b0, 7'b0111000);
      idle();
      for (int i = 0; i < 50 && sb.size() != 0; i++) @(posedge clk);
      #1;
      check("drain_final", sb.size(), 32'd0);
      repeat (3) @(posedge clk);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/posit_field_extract.md
POSIT_FIELD_EXTRACT -- requirements
Module: posit_field_extract

Interface
REQ-001 The block SHALL take parameter N, default 8: posit width in bits; N >= ES+4 SHALL hold.
REQ-002 The block SHALL take parameter ES, default 3: exponent field width.
REQ-003 The block SHALL take parameter RS, default log2(N) (ceiling): run-length field width minus one.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-006 The block SHALL have port in_valid, input, 1 bit: an operand is presented.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the operand is accepted when in_valid && in_ready.
REQ-008 The block SHALL have port in_sign, input, 1 bit: posit sign bit.
REQ-009 The block SHALL have port in_remain, input, N-1 bits: posit bits [N-2:0], already two's-complemented when negative.
REQ-010 The block SHALL have port in_endpos, input, RS+1 bits: regime run count from the leading-bit detector, range 1..N-2.
REQ-011 The block SHALL have port in_rc, input, 1 bit: regime check bit, equal to in_remain[N-2].
REQ-012 The block SHALL have port out_valid, output, 1 bit: the output fields hold a result.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result when out_valid && out_ready.
REQ-014 The block SHALL have port out_sign, output, 1 bit: sign, passed through unchanged.
REQ-015 The block SHALL have port out_k, output, RS+1 bits, signed: regime value k.
REQ-016 The block SHALL have port out_exp, output, ES bits: exponent, zero-padded on the right when truncated.
REQ-017 The block SHALL have port out_mant, output, N-ES-2 bits: hidden 1 followed by N-ES-3 fraction bits, zero-padded.

Function
REQ-018 The run length m SHALL be in_endpos, except m SHALL be N-1 when in_endpos == N-2 and in_remain[0] == in_rc (saturated run).
REQ-019 k SHALL be m-1 when in_rc == 1 and SHALL be -m when in_rc == 0.
REQ-020 The number of regime bits consumed SHALL be min(m+1, N-1); the remaining bits SHALL be left-aligned by this amount, with zeros shifted in.
REQ-021 out_exp SHALL be the top ES bits of the aligned remainder, and the fraction SHALL be the next N-ES-3 bits.
REQ-022 Stage 1 SHALL register the sign, k, and the aligned remainder; stage 2 SHALL register the split fields; latency from acceptance to out_valid SHALL be 2 cycles without stall.
REQ-023 Each stage SHALL advance when it is empty or the downstream stage advances; in_ready SHALL be high when stage 1 is empty or will advance this cycle.
REQ-024 While out_valid && !out_ready, all output fields SHALL hold stable and no accepted operand SHALL be lost or duplicated.
REQ-025 Simultaneous acceptance and output consumption SHALL sustain a throughput of one operand per cycle.
REQ-026 Input fields SHALL be ignored when in_valid is low.

Reset
REQ-027 On rst high at a clock edge, both stage valid bits, out_valid, and every output field (out_sign, out_k, out_exp, out_mant, and the flags when present) SHALL become 0.
REQ-028 Operands in flight when rst is asserted mid-operation SHALL be discarded.
REQ-029 in_ready SHALL be 1 in the cycle after reset deasserts.

Configuration
REQ-030 When macro POSIT_EXTRACT_SPECIAL_EN is defined, the block SHALL add output ports out_zero and out_nar, each 1 bit and pipelined with the data.
REQ-031 With POSIT_EXTRACT_SPECIAL_EN defined, out_zero SHALL be set when in_sign == 0 and in_remain is all zero; out_nar SHALL be set when in_sign == 1 and in_remain is all zero; in both cases out_k, out_exp and out_mant SHALL be 0.
REQ-032 When POSIT_EXTRACT_SPECIAL_EN is undefined, the flag ports SHALL be absent, and all-zero inputs SHALL be decoded through REQ-018 to REQ-021 like any other value.

Verification (N=8, ES=3)
REQ-033 Stimulus remain=1011010, endpos=1, rc=1, sign=0 -> two cycles later: k=0, exp=110, mant=110.
REQ-034 Stimulus remain=0001101, endpos=3, rc=0 -> k=-3 (4'b1101), exp=101, mant=100.
REQ-035 Stimulus remain=1111111, endpos=6, rc=1 -> k=6, exp=000, mant=100 (saturated run).
REQ-036 Stream 4 operands back-to-back while out_ready is held low 3 cycles -> in_ready drops; outputs stay stable; all 4 results arrive in order with no loss.
REQ-037 Assert rst while 2 operands are in flight -> out_valid=0 the next cycle and no stale result ever appears.
REQ-038 With POSIT_EXTRACT_SPECIAL_EN: sign=1, remain=0000000 -> out_nar=1, out_zero=0, k=0.
